// File: rtl/decoder_proj_pkg.sv
// Shared constants and FSM encoding for the decoder_proj input framer.
package decoder_proj_pkg;
  localparam int CODE_W          = 7;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    WAIT  = 2'd3
  } frm_state_e;
endpackage

// File: rtl/decoder_sync.sv
// N-stage single-bit synchronizer, asynchronous active-low reset.
module decoder_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/decoder_in_framer.sv
// Serial pad framer feeding the decoder io_in word through a valid/ready hold register.
// Optional macro DECODER_IN_PARITY_EN adds a trailing even-parity bit and parity_err.
module decoder_in_framer
  import decoder_proj_pkg::*;
#(
  parameter int WIDTH       = CODE_W,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             ser_clk,
  input  logic             ser_din,
  input  logic             ser_frm,
  output logic [WIDTH-1:0] code,
  output logic             code_valid,
  input  logic             code_ready,
  output logic             overrun,
  input  logic             overrun_clr
`ifdef DECODER_IN_PARITY_EN
  ,
  output logic             parity_err
`endif
);
`ifdef DECODER_IN_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  logic [2:0] pads, s_pads;
  logic       s_clk, s_din, s_frm, s_clk_d, s_frm_d, rise, frm_rise;

  assign pads = {ser_frm, ser_din, ser_clk};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    decoder_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clock (clock),
      .rst_n (rst_n),
      .d     (pads[g]),
      .q     (s_pads[g])
    );
  end

  assign {s_frm, s_din, s_clk} = s_pads;
  assign rise     = s_clk & ~s_clk_d;
  assign frm_rise = s_frm & ~s_frm_d;

  frm_state_e             state, state_nxt;
  logic [FRAME_BITS-1:0]  sreg;
  logic [CNT_W-1:0]       cnt;
  logic                   last_bit, accept;

  assign last_bit = (cnt == CNT_W'(FRAME_BITS - 1));
  // A word already being consumed this cycle frees the hold register for the new one.
  assign accept   = ~code_valid | code_ready;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (frm_rise) state_nxt = SHIFT;
      SHIFT: begin
        if (!s_frm)                state_nxt = IDLE;
        else if (rise && last_bit) state_nxt = LOAD;
      end
      LOAD:  state_nxt = WAIT;
      WAIT:  if (!s_frm) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s_clk_d    <= 1'b0;
      s_frm_d    <= 1'b0;
      sreg       <= '0;
      cnt        <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef DECODER_IN_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      s_clk_d <= s_clk;
      s_frm_d <= s_frm;
      if (code_valid && code_ready) code_valid <= 1'b0;
      if (overrun_clr)              overrun    <= 1'b0;
`ifdef DECODER_IN_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: if (frm_rise) begin
          sreg <= '0;
          cnt  <= '0;
        end
        SHIFT: if (s_frm && rise) begin
          sreg <= {sreg[FRAME_BITS-2:0], s_din};
          cnt  <= cnt + 1'b1;
        end
        LOAD: begin
`ifdef DECODER_IN_PARITY_EN
          if (^sreg) parity_err <= 1'b1;
          else
`endif
          if (accept) begin
            code       <= sreg[FRAME_BITS-1 -: WIDTH];
            code_valid <= 1'b1;
          end else begin
            overrun    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_decoder_in_framer.sv
// Self-checking bench for decoder_in_framer: vector table, hand sequences, random frames vs model.
module tb_decoder_in_framer;
  import decoder_proj_pkg::*;

  localparam int W = CODE_W;
  localparam int N = SYNC_STAGES_DEF;
`ifdef DECODER_IN_PARITY_EN
  localparam int FB = W + 1;
`else
  localparam int FB = W;
`endif

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic         ser_clk = 1'b0, ser_din = 1'b0, ser_frm = 1'b0;
  logic         code_ready = 1'b0, overrun_clr = 1'b0;
  logic [W-1:0] code;
  logic         code_valid, overrun;
`ifdef DECODER_IN_PARITY_EN
  logic         parity_err;
  int           perr_cnt = 0;
  always @(posedge clock) if (parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
`endif

  decoder_in_framer dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .ser_clk     (ser_clk),
    .ser_din     (ser_din),
    .ser_frm     (ser_frm),
    .code        (code),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
`ifdef DECODER_IN_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0;

  // reference model state: what the decoder should be seeing
  logic [W-1:0] m_code = '0;
  bit           m_valid = 0, m_ovr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic start_frame();
    ser_clk = 1'b0;
    ser_frm = 1'b1;
    tick(4);
  endtask

  // Sends the first nb frame bits MSB-first; parity bit follows the word when enabled.
  task automatic send_bits(input logic [W-1:0] w, input int nb, input bit bad_par, input bit hold_last);
    logic [W:0]    full;
    logic [FB-1:0] f;
    full = {w, (^w) ^ bad_par};
    f    = full[W -: FB];
    for (int i = 0; i < nb; i++) begin
      ser_din = f[FB-1-i];
      tick(3);
      ser_clk = 1'b1;
      if (i == nb - 1 && hold_last) return;
      tick(4);
      ser_clk = 1'b0;
    end
  endtask

  task automatic end_frame();
    tick(4);
    ser_clk = 1'b0;
    tick(4);
    ser_frm = 1'b0;
    tick(8);
  endtask

  task automatic frame(input logic [W-1:0] w, input int nb, input bit bad_par);
    start_frame();
    send_bits(w, nb, bad_par, 1'b0);
    end_frame();
  endtask

  task automatic consume();
    code_ready = 1'b1;
    tick(1);
    code_ready = 1'b0;
    m_valid = 0;
  endtask

  task automatic clear_ovr();
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    m_ovr = 0;
  endtask

  function automatic void model_frame(input logic [W-1:0] w, input int nb, input bit bad_par);
    if (nb != FB || bad_par) return;
    if (!m_valid) begin
      m_code  = w;
      m_valid = 1;
    end else begin
      m_ovr = 1;
    end
  endfunction

  task automatic chk_model(input string nm);
    chk({nm, ".code"},    32'(code),       32'(m_code));
    chk({nm, ".valid"},   32'(code_valid), 32'(m_valid));
    chk({nm, ".overrun"}, 32'(overrun),    32'(m_ovr));
  endtask

  typedef struct {
    logic [W-1:0] w;
    int           nb;
    bit           cons;
    bit           clr;
    logic [W-1:0] e_code;
    bit           e_valid;
    bit           e_ovr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{7'b0000101, FB, 1, 0, 7'b0000101, 1, 0};
    vecs[1] = '{7'b1010101, FB, 1, 0, 7'b1010101, 1, 0};
    vecs[2] = '{7'b0110011, FB, 0, 0, 7'b1010101, 1, 1};
    vecs[3] = '{7'b1110000, 4,  1, 1, 7'b1010101, 0, 0};
    vecs[4] = '{7'b1100110, FB, 0, 0, 7'b1100110, 1, 0};

    // reset held while pads wiggle
    for (int i = 0; i < 12; i++) begin
      ser_clk = 1'($urandom);
      ser_din = 1'($urandom);
      ser_frm = 1'($urandom);
      tick(1);
      chk("reset_hold", {code, code_valid, overrun}, '0);
    end
    ser_clk = 1'b0; ser_din = 1'b0; ser_frm = 1'b0;
    tick(4);
    rst_n = 1'b1;
    // serial clocks without a frame strobe must not produce anything
    for (int i = 0; i < 6; i++) begin
      ser_clk = ~ser_clk;
      ser_din = 1'($urandom);
      tick(5);
    end
    ser_clk = 1'b0;
    tick(6);
    chk("idle_after_reset", {code, code_valid, overrun}, '0);

    // basic frame; frame strobe and ser_clk rise together so that edge is not a bit
    ser_frm = 1'b1; ser_clk = 1'b1; ser_din = 1'b1;
    tick(4);
    ser_clk = 1'b0;
    tick(3);
    send_bits(7'b1111010, FB, 1'b0, 1'b1);
    tick(N + 1);
    chk("basic.valid_early", 32'(code_valid), 32'd0);
    tick(1);
    chk("basic.valid_on_time", 32'(code_valid), 32'd1);
    chk("basic.code", 32'(code), 32'(7'b1111010));
    end_frame();
    m_code = 7'b1111010; m_valid = 1;

    // handshake: one ready cycle drops valid on the next cycle
    code_ready = 1'b1;
    tick(1);
    code_ready = 1'b0;
    chk("handshake.valid_low", 32'(code_valid), 32'd0);
    code_ready = 1'b1; tick(1); code_ready = 1'b0;

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].cons) consume();
      if (vecs[i].clr)  clear_ovr();
      frame(vecs[i].w, vecs[i].nb, 1'b0);
      chk($sformatf("vec%0d.code", i),    32'(code),       32'(vecs[i].e_code));
      chk($sformatf("vec%0d.valid", i),   32'(code_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.overrun", i), 32'(overrun),    32'(vecs[i].e_ovr));
    end
    m_code = 7'b1100110; m_valid = 1; m_ovr = 0;

    // overrun set in the same cycle as overrun_clr: set wins
    start_frame();
    send_bits(7'b0011001, FB, 1'b0, 1'b1);
    overrun_clr = 1'b1;
    tick(N + 2);
    overrun_clr = 1'b0;
    chk("set_wins.overrun", 32'(overrun), 32'd1);
    chk("set_wins.code", 32'(code), 32'(7'b1100110));
    end_frame();
    m_ovr = 1;
    clear_ovr();
    chk("overrun_clr", 32'(overrun), 32'd0);

`ifdef DECODER_IN_PARITY_EN
    begin
      int p0;
      consume();
      p0 = perr_cnt;
      frame(7'b1111010, FB, 1'b1);
      chk("parity_bad.err_pulses", 32'(perr_cnt - p0), 32'd1);
      chk("parity_bad.valid", 32'(code_valid), 32'd0);
      chk("parity_bad.overrun", 32'(overrun), 32'd0);
      frame(7'b1111010, FB, 1'b0);
      chk("parity_good.code", 32'(code), 32'(7'b1111010));
      chk("parity_good.valid", 32'(code_valid), 32'd1);
      m_code = 7'b1111010; m_valid = 1;
    end
`endif

    // randomized frames against the model
    for (int it = 0; it < 40; it++) begin
      logic [W-1:0] w;
      int           nb;
      bit           bad;
      int           p0;
      w   = W'($urandom);
      nb  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, FB - 1)) : FB;
      bad = 0;
`ifdef DECODER_IN_PARITY_EN
      bad = ($urandom_range(0, 4) == 0);
      p0  = perr_cnt;
`else
      p0  = 0;
`endif
      if ($urandom_range(0, 1) == 1) consume();
      if ($urandom_range(0, 3) == 0) clear_ovr();
      frame(w, nb, bad);
      model_frame(w, nb, bad);
      chk_model($sformatf("rand%0d", it));
`ifdef DECODER_IN_PARITY_EN
      chk($sformatf("rand%0d.perr", it), 32'(perr_cnt - p0), 32'(nb == FB && bad));
`else
      if (p0 != 0) chk("rand.p0", 32'(p0), 32'd0);
`endif
    end

    // reset in the middle of a frame discards the partial word
    start_frame();
    send_bits(7'b1011011, 4, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick(2);
    chk("midreset.outputs", {code, code_valid, overrun}, '0);
    ser_frm = 1'b0; ser_clk = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    frame(7'b0101101, FB, 1'b0);
    chk("midreset.code", 32'(code), 32'(7'b0101101));
    chk("midreset.valid", 32'(code_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
